rot_share_arb: RTL and testbench

- Arbitrates two requesters onto a single shared 8-bit rotator. The rotator is one instance of the team's combinational barrel_shifter (rotate right by k[2:0]).
- Accepts operand, rotation amount and direction through valid/ready handshakes, and sequences each operation through the shared rotator.
- Returns a registered result, tagged with the requester ID, through a valid/ready output.
- Sits between the bit-manipulation clients and the shifter datapath; it is the only block permitted to drive the shifter.

---
 rtl/rot_share_arb.sv | 182 ++++++++++++++++++
 tb/tb_rot_share_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rot_share_arb.sv
// Two-requester round-robin arbiter in front of one shared 8-bit rotator.
// Each accepted operation is sequenced IDLE -> ROT -> DONE and returns a registered, ID-tagged result.

module barrel_shifter (
  input  logic [7:0] a_i,
  input  logic [2:0] k_i,
  output logic [7:0] y_o
);

  // Rotate right: the low byte of the doubled operand shifted right by k.
  always_comb begin
    y_o = 8'({a_i, a_i} >> k_i);
  end

endmodule

module rot_share_arb #(
  parameter int AMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [7:0]       req0_data_i,
  input  logic [AMT_W-1:0] req0_amt_i,
  input  logic             req0_dir_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [7:0]       req1_data_i,
  input  logic [AMT_W-1:0] req1_amt_i,
  input  logic             req1_dir_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [7:0]       res_data_o,
  output logic             res_id_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_gnt_q;
  logic       id_q;
  logic [7:0] data_q;
  logic [2:0] amt_q;
  logic       dir_q;
  logic       res_valid_q;
  logic [7:0] res_data_q;
  logic       res_id_q;

  logic       gnt_s;
  logic       ready0_s;
  logic       ready1_s;
  logic       accept_s;
  logic [2:0] k_s;
  logic [7:0] rot_y_s;

  // On a tie the requester that did not win last time is served.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    logic g;
    case ({v1, v0})
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = ~last;
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  // A left rotate by n is a right rotate by (8 - n) in 3-bit wrap arithmetic.
  function automatic logic [2:0] rot_amount(input logic [2:0] amt, input logic dir);
    logic [2:0] k;
    if (dir) begin
      k = 3'd0 - amt;
    end else begin
      k = amt;
    end
    return k;
  endfunction

  function automatic logic [2:0] wrap_amt(input logic [AMT_W-1:0] amt);
    return 3'(amt);
  endfunction

  // Next-state, grant and handshake decode.
  always_comb begin
    state_d  = state_q;
    gnt_s    = pick_grant(req0_valid_i, req1_valid_i, last_gnt_q);
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst_i && (req0_valid_i || req1_valid_i)) begin
          ready0_s = (gnt_s == 1'b0);
          ready1_s = (gnt_s == 1'b1);
          accept_s = 1'b1;
          state_d  = ST_ROT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ROT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign k_s = rot_amount(amt_q, dir_q);

  barrel_shifter u_rot (
    .a_i (data_q),
    .k_i (k_s),
    .y_o (rot_y_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, round-robin pointer and registered result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q  <= 1'b1;
      id_q        <= 1'b0;
      data_q      <= 8'h00;
      amt_q       <= 3'd0;
      dir_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_id_q    <= 1'b0;
    end else begin
      if (accept_s) begin
        last_gnt_q <= gnt_s;
        id_q       <= gnt_s;
        if (gnt_s) begin
          data_q <= req1_data_i;
          amt_q  <= wrap_amt(req1_amt_i);
          dir_q  <= req1_dir_i;
        end else begin
          data_q <= req0_data_i;
          amt_q  <= wrap_amt(req0_amt_i);
          dir_q  <= req0_dir_i;
        end
      end
      if (state_q == ST_ROT) begin
        res_valid_q <= 1'b1;
        res_data_q  <= rot_y_s;
        res_id_q    <= id_q;
      end else if ((state_q == ST_DONE) && res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign req0_ready_o = ready0_s;
  assign req1_ready_o = ready1_s;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_id_o     = res_id_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rot_share_arb.sv
// Directed bench for rot_share_arb: arbitration, rotation results, backpressure and reset behaviour.

module tb_rot_share_arb;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_dir;
  logic [7:0] req0_data;
  logic [4:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [7:0] req1_data;
  logic [4:0] req1_amt;
  logic       res_valid, res_ready, res_id, busy;
  logic [7:0] res_data;

  int n_cmp  = 0;
  int n_fail = 0;

  rot_share_arb #(.AMT_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_data_i  (req0_data),
    .req0_amt_i   (req0_amt),
    .req0_dir_i   (req0_dir),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_data_i  (req1_data),
    .req1_amt_i   (req1_amt),
    .req1_dir_i   (req1_dir),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_id_o     (res_id),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with the requests already applied.
  task automatic op(input logic exp_id, input logic [7:0] exp_data);
    #1;
    check("ready0", {7'd0, req0_ready}, {7'd0, exp_id == 1'b0});
    check("ready1", {7'd0, req1_ready}, {7'd0, exp_id == 1'b1});
    @(posedge clk); @(negedge clk);
    if (exp_id) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
    check("rot_busy", {7'd0, busy}, 8'd1);
    check("rot_valid", {7'd0, res_valid}, 8'd0);
    @(posedge clk); @(negedge clk);
    check("done_valid", {7'd0, res_valid}, 8'd1);
    check("done_data", res_data, exp_data);
    check("done_id", {7'd0, res_id}, {7'd0, exp_id});
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check("post_valid", {7'd0, res_valid}, 8'd0);
    check("post_busy", {7'd0, busy}, 8'd0);
    check("post_data_hold", res_data, exp_data);
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hB4; req0_amt = 5'd3; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 5'd0; req1_dir = 1'b0;
    #2;
    check("rst_valid", {7'd0, res_valid}, 8'd0);
    check("rst_data", res_data, 8'h00);
    check("rst_id", {7'd0, res_id}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_ready0", {7'd0, req0_ready}, 8'd0);
    check("rst_ready1", {7'd0, req1_ready}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(1'b0, 8'h96);
    req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 5'd1; req1_dir = 1'b1;
    op(1'b1, 8'h03);
    req0_valid = 1'b1; req0_data = 8'hB4; req0_amt = 5'd11; req0_dir = 1'b0;
    op(1'b0, 8'h96);
    req0_valid = 1'b1; req0_data = 8'h5A; req0_amt = 5'd8; req0_dir = 1'b1;
    op(1'b0, 8'h5A);

    // Tie straight out of reset, then alternating grants.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 5'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 5'd1; req1_dir = 1'b1;
    op(1'b0, 8'h80);
    op(1'b1, 8'h02);
    req0_valid = 1'b1; req1_valid = 1'b1;
    op(1'b0, 8'h80);
    req0_valid = 1'b1;
    op(1'b1, 8'h02);
    req1_valid = 1'b1;
    op(1'b0, 8'h80);
    req0_valid = 1'b1;
    op(1'b1, 8'h02);
    req0_valid = 1'b0;

    // Backpressure in DONE with a request pending.
    req0_valid = 1'b1; req0_data = 8'hB4; req0_amt = 5'd3; req0_dir = 1'b0;
    #1;
    check("bp_ready0", {7'd0, req0_ready}, 8'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 5'd1; req1_dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", {7'd0, res_valid}, 8'd1);
      check("bp_data", res_data, 8'h96);
      check("bp_id", {7'd0, res_id}, 8'd0);
      check("bp_ready0", {7'd0, req0_ready}, 8'd0);
      check("bp_ready1", {7'd0, req1_ready}, 8'd0);
      check("bp_busy", {7'd0, busy}, 8'd1);
      @(posedge clk); @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check("bp_release_valid", {7'd0, res_valid}, 8'd0);
    op(1'b1, 8'h03);

    // Asynchronous reset while in ROT.
    req0_valid = 1'b1; req0_data = 8'h5A; req0_amt = 5'd1; req0_dir = 1'b0;
    #1;
    check("mr_ready0", {7'd0, req0_ready}, 8'd1);
    @(posedge clk);
    #2 req0_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mr_valid", {7'd0, res_valid}, 8'd0);
    check("mr_data", res_data, 8'h00);
    check("mr_id", {7'd0, res_id}, 8'd0);
    check("mr_busy", {7'd0, busy}, 8'd0);
    check("mr_ready0", {7'd0, req0_ready}, 8'd0);
    check("mr_ready1", {7'd0, req1_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("mr_no_result", {7'd0, res_valid}, 8'd0);
      check("mr_idle", {7'd0, busy}, 8'd0);
    end
    req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 5'd1; req1_dir = 1'b1;
    op(1'b1, 8'h03);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 5'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 5'd1; req1_dir = 1'b1;
    op(1'b0, 8'h80);
    op(1'b1, 8'h02);

    // req0 pulses valid only while in DONE and must never be served.
    req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 5'd5; req1_dir = 1'b0;
    #1;
    check("wd_ready1", {7'd0, req1_ready}, 8'd1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 5'd2; req0_dir = 1'b0;
    #1;
    check("wd_ready0", {7'd0, req0_ready}, 8'd0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    check("wd_valid", {7'd0, res_valid}, 8'd1);
    check("wd_data", res_data, 8'h0C);
    check("wd_id", {7'd0, res_id}, 8'd1);
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wd_no_result", {7'd0, res_valid}, 8'd0);
      check("wd_idle", {7'd0, busy}, 8'd0);
      check("wd_id_hold", {7'd0, res_id}, 8'd1);
      @(posedge clk); @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
